// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial TX/RX blocks: default frame width and FSM states.
package piso_tx_pkg;

  localparam int unsigned PISO_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_tx_4bit.sv
// Parallel-in serial-out transmitter: LSB-first frames of WIDTH bits with
// back-to-back reload on the last bit.
module piso_tx_4bit
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             READY,
  output logic             SOUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             last_bit;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    case (state_q)
      IDLE: begin
        if (LOAD) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sreg_d  = DIN;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Last bit: either reload for a gapless next frame or return to idle
        if (last_bit) begin
          cnt_d = '0;
          if (LOAD) begin
            sreg_d = DIN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign READY = (state_q == IDLE) || last_bit;
  assign DONE  = last_bit;
  assign VALID = (state_q == SHIFT);
  assign BUSY  = (state_q == SHIFT);
  assign SOUT  = (state_q == SHIFT) & sreg_q[0];

endmodule

// File: tb/tb_piso_tx_4bit.sv
// Directed table-driven bench for piso_tx_4bit plus a serial loopback sequence.
module tb_piso_tx_4bit;

  logic       clk;
  logic       clr;
  logic       load;
  logic [3:0] din;
  logic       ready, sout, valid, busy, done;
  logic [3:0] lb_q;

  int checks;
  int errors;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] din;
    logic       chk;
    logic [4:0] exp; // {ready, sout, valid, busy, done}
  } vec_t;

  vec_t vecs[$];

  piso_tx_4bit #(.WIDTH(4)) dut (
    .CLK   (clk),
    .CLR   (clr),
    .LOAD  (load),
    .DIN   (din),
    .READY (ready),
    .SOUT  (sout),
    .VALID (valid),
    .BUSY  (busy),
    .DONE  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference serial-in shifter: MSB-in, shifts toward bit 0 when VALID
  always_ff @(posedge clk) begin
    if (valid) lb_q <= {sout, lb_q[3:1]};
  end

  localparam logic [4:0] E_IDLE = 5'b10000;

  function automatic logic [4:0] e_bit(input logic b, input logic last);
    return {last, b, 1'b1, 1'b1, last};
  endfunction

  task automatic add(input logic c, input logic l, input logic [3:0] d,
                     input logic k, input logic [4:0] e);
    vec_t v;
    v.clr = c; v.load = l; v.din = d; v.chk = k; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_bit(name, done, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b1; load = 1'b0; din = 4'h0;

    // Frame 4'b1011 after reset; DIN changes after acceptance
    add(1, 0, 4'h0, 0, E_IDLE);
    add(0, 1, 4'hB, 1, E_IDLE);
    add(0, 0, 4'h0, 1, e_bit(1, 0));
    add(0, 0, 4'h0, 1, e_bit(1, 0));
    add(0, 0, 4'h0, 1, e_bit(0, 0));
    add(0, 0, 4'h0, 1, e_bit(1, 1));
    add(0, 0, 4'h0, 1, E_IDLE);
    // LOAD held high: 4'h3 then 4'hC back-to-back
    add(0, 1, 4'h3, 1, E_IDLE);
    add(0, 1, 4'hC, 1, e_bit(1, 0));
    add(0, 1, 4'hC, 1, e_bit(1, 0));
    add(0, 1, 4'hC, 1, e_bit(0, 0));
    add(0, 1, 4'hC, 1, e_bit(0, 1));
    add(0, 0, 4'h0, 1, e_bit(0, 0));
    add(0, 0, 4'h0, 1, e_bit(0, 0));
    add(0, 0, 4'h0, 1, e_bit(1, 0));
    add(0, 0, 4'h0, 1, e_bit(1, 1));
    add(0, 0, 4'h0, 1, E_IDLE);
    // 4'h0 frame with an ignored 4'hF pulse at bit 2
    add(0, 1, 4'h0, 1, E_IDLE);
    add(0, 0, 4'h0, 1, e_bit(0, 0));
    add(0, 0, 4'h0, 1, e_bit(0, 0));
    add(0, 1, 4'hF, 1, e_bit(0, 0));
    add(0, 0, 4'h0, 1, e_bit(0, 1));
    add(0, 0, 4'h0, 1, E_IDLE);
    // 4'hF frame cleared at bit 2 (CLR beats LOAD), then LOAD 4'h1 right after
    add(0, 1, 4'hF, 1, E_IDLE);
    add(0, 0, 4'h0, 1, e_bit(1, 0));
    add(0, 0, 4'h0, 1, e_bit(1, 0));
    add(1, 1, 4'hF, 1, e_bit(1, 0));
    add(0, 1, 4'h1, 1, E_IDLE);
    add(0, 0, 4'h0, 1, e_bit(1, 0));
    add(0, 0, 4'h0, 1, e_bit(0, 0));
    add(0, 0, 4'h0, 1, e_bit(0, 0));
    add(0, 0, 4'h0, 1, e_bit(0, 1));
    add(0, 0, 4'h0, 1, E_IDLE);

    foreach (vecs[i]) begin
      @(negedge clk);
      clr  = vecs[i].clr;
      load = vecs[i].load;
      din  = vecs[i].din;
      #1;
      if (vecs[i].chk) begin
        checks++;
        if ({ready, sout, valid, busy, done} !== vecs[i].exp) begin
          errors++;
          $display("FAIL row%0d: {rdy,sout,vld,busy,done} got %b expected %b",
                   i, {ready, sout, valid, busy, done}, vecs[i].exp);
        end
      end
    end

    // Loopback: 4'hA then 4'h5 back-to-back into the reference shifter
    @(negedge clk);
    clr = 1'b0; load = 1'b1; din = 4'hA;
    @(negedge clk);
    load = 1'b0; din = 4'h0;
    #1;
    wait_done("lb_done_a");
    load = 1'b1; din = 4'h5;
    @(negedge clk);
    load = 1'b0; din = 4'h0;
    #1;
    checks++;
    if (lb_q !== 4'hA) begin
      errors++;
      $display("FAIL lb_word_a: got %h expected %h", lb_q, 4'hA);
    end
    wait_done("lb_done_5");
    @(negedge clk);
    #1;
    checks++;
    if (lb_q !== 4'h5) begin
      errors++;
      $display("FAIL lb_word_5: got %h expected %h", lb_q, 4'h5);
    end
    check_bit("lb_idle_busy", busy, 1'b0);
    check_bit("lb_idle_ready", ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
